// File: rtl/mhbf_cfg_pkg.sv
// mhbf_cfg_pkg: shared types and constants for the MHBF configuration loader.
//   cfg_len()  : words per configuration image (control word + per-stage coeffs)
//   state_t    : loader FSM encoding
//   ERR_*      : error codes reported on err_code
package mhbf_cfg_pkg;

    function automatic int cfg_len(input int nstages, input int max_order);
        return 1 + (max_order + 3) * nstages;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ACK_TO   = 2'd1;
    localparam logic [1:0] ERR_ACK_LOST = 2'd2;
    localparam logic [1:0] ERR_DONE_TO  = 2'd3;

endpackage

// File: rtl/mhbf_cfg_loader_if.sv
// mhbf_cfg_loader_if: host buffer/commit port, MHBF config handshake and status.
//   host side  : wr_en, wr_addr, wr_data, commit -> loader; busy, done, err, err_code, reject <- loader
//   MHBF side  : cfg_req, cfg_data <- loader; cfg_ack, cfg_done -> loader
//   master     : the host + MHBF controller side
//   slave      : the loader
interface mhbf_cfg_loader_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int COEFF_WIDTH = 24
);
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COEFF_WIDTH-1:0] wr_data;
    logic                   commit;
    logic                   cfg_req;
    logic                   cfg_ack;
    logic                   cfg_done;
    logic [COEFF_WIDTH-1:0] cfg_data;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;
    logic                   reject;

    modport master (
        output wr_en, wr_addr, wr_data, commit, cfg_ack, cfg_done,
        input  cfg_req, cfg_data, busy, done, err, err_code, reject
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, cfg_ack, cfg_done,
        output cfg_req, cfg_data, busy, done, err, err_code, reject
    );

endinterface

// File: rtl/mhbf_cfg_buf.sv
// mhbf_cfg_buf: DEPTH x DW simple dual-port coefficient buffer with registered read.
//   i_clk, i_rst_n      : clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata: write port
//   i_re/i_raddr        : read enable/address, data appears next cycle on o_rdata
//   i_clr               : zero the read register (has priority over i_re)
//   o_rdata             : registered read data
module mhbf_cfg_buf #(
    parameter int DEPTH = 176,
    parameter int AW    = 8,
    parameter int DW    = 24
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_clr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Write-first bypass so a commit issued with a write to word 0 streams the new value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else if (i_clr) r_rdata <= '0;
        else if (i_re) r_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mhbf_cfg_loader.sv
// mhbf_cfg_loader: buffers a host-written MHBF coefficient image and, on commit,
// streams it to the MHBF config controller via request/ACK/stream/done, with timeouts.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : host write/commit/status and MHBF handshake (slave modport)
module mhbf_cfg_loader
    import mhbf_cfg_pkg::*;
#(
    parameter int NMHBF_MAX        = 5,
    parameter int COEFF_WIDTH      = 24,
    parameter int FILTER_MAX_ORDER = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int TIMEOUT_CYC      = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mhbf_cfg_loader_if.slave  io_bus
);
    localparam int CFG_LEN = cfg_len(NMHBF_MAX, FILTER_MAX_ORDER);
    localparam int TW      = $clog2(TIMEOUT_CYC);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(CFG_LEN - 1);
    localparam logic [TW-1:0]         T_MAX    = TW'(TIMEOUT_CYC - 1);

    state_t                 r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_ptr, w_ptr_nxt, w_raddr;
    logic [TW-1:0]          r_timer, w_timer_nxt;
    logic [1:0]             r_err_code, w_err_code_nxt;
    logic                   r_done, r_reject;
    logic                   w_busy, w_wr_ok, w_re, w_rclr;
    logic [COEFF_WIDTH-1:0] w_rdata;

    assign w_busy  = r_state inside {ST_REQ, ST_STREAM, ST_WAIT_DONE};
    assign w_wr_ok = io_bus.wr_en && !w_busy && (int'(io_bus.wr_addr) < CFG_LEN);

    mhbf_cfg_buf #(
        .DEPTH(CFG_LEN),
        .AW   (ADDR_WIDTH),
        .DW   (COEFF_WIDTH)
    ) u_buf (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_we   (w_wr_ok),
        .i_waddr(io_bus.wr_addr),
        .i_wdata(io_bus.wr_data),
        .i_re   (w_re),
        .i_raddr(w_raddr),
        .i_clr  (w_rclr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_timer    <= '0;
            r_err_code <= ERR_NONE;
            r_done     <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_timer    <= w_timer_nxt;
            r_err_code <= w_err_code_nxt;
            r_done     <= r_state == ST_WAIT_DONE && io_bus.cfg_done;
            r_reject   <= (io_bus.wr_en && !w_wr_ok) || (io_bus.commit && w_busy);
        end
    end

    // The buffer read is issued one edge ahead so cfg_data always holds the word
    // the controller captures at the next ACK edge; timers only count below T_MAX,
    // so they saturate there.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_timer_nxt    = r_timer;
        w_err_code_nxt = r_err_code;
        w_re           = 1'b0;
        w_raddr        = '0;
        w_rclr         = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_ERR: begin
                if (io_bus.commit) begin
                    w_state_nxt    = ST_REQ;
                    w_ptr_nxt      = '0;
                    w_timer_nxt    = '0;
                    w_err_code_nxt = ERR_NONE;
                    w_re           = 1'b1;
                end
            end
            ST_REQ: begin
                if (io_bus.cfg_ack) begin
                    w_state_nxt = ST_STREAM;
                    w_ptr_nxt   = ADDR_WIDTH'(1);
                    w_re        = 1'b1;
                    w_raddr     = ADDR_WIDTH'(1);
                end else if (r_timer == T_MAX) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_ACK_TO;
                    w_rclr         = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_STREAM: begin
                if (!io_bus.cfg_ack) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_ACK_LOST;
                    w_rclr         = 1'b1;
                end else if (r_ptr == LAST_PTR) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_timer_nxt = '0;
                    w_rclr      = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    w_re      = 1'b1;
                    w_raddr   = r_ptr + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (io_bus.cfg_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == T_MAX) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_DONE_TO;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        io_bus.cfg_req  = r_state == ST_REQ;
        io_bus.cfg_data = w_rdata;
        io_bus.busy     = w_busy;
        io_bus.err      = r_state == ST_ERR;
        io_bus.err_code = r_err_code;
        io_bus.done     = r_done;
        io_bus.reject   = r_reject;
    end

endmodule

// File: tb/tb_mhbf_cfg_loader.sv
// tb_mhbf_cfg_loader: scoreboard bench with a behavioural MHBF controller model.
module tb_mhbf_cfg_loader;
    localparam int CL = 176;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mhbf_cfg_loader_if #(.ADDR_WIDTH(8), .COEFF_WIDTH(24)) bus ();

    mhbf_cfg_loader dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [23:0] bm [CL];
    logic [31:0] exp_q [$];
    int ack_dly = 1, drop_at = -1, done_dly = 200, xtra = 0;
    int m_st = 0, m_cnt = 0, m_n = 0, m_x = 0;
    int n_done = 0, n_rej = 0, n_req = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // MHBF controller model: ACKs ack_dly cycles after seeing a request, holds ACK
    // while streaming (optionally xtra cycles past the last word or dropping early),
    // then pulses done done_dly cycles later. Captured words are popped and compared.
    always @(negedge clk) begin
        bus.cfg_done = 1'b0;
        n_done += int'(bus.done);
        n_rej  += int'(bus.reject);
        n_req  += int'(bus.cfg_req);
        if (!bus.busy) begin
            m_st = 0;
            bus.cfg_ack = 1'b0;
        end
        case (m_st)
            0: if (bus.cfg_req) begin
                m_st = 1; m_cnt = 0; m_n = 0; m_x = 0;
            end
            1: begin
                m_cnt++;
                if (m_cnt >= ack_dly) begin
                    bus.cfg_ack = 1'b1;
                    m_st = 2;
                end
            end
            2: if (m_n == drop_at) begin
                bus.cfg_ack = 1'b0;
                m_st = 0;
            end else if (m_n == CL) begin
                if (m_x == xtra) begin
                    bus.cfg_ack = 1'b0;
                    m_st = 3;
                    m_cnt = 0;
                end else m_x++;
            end
            3: begin
                m_cnt++;
                if (m_cnt >= done_dly) begin
                    bus.cfg_done = 1'b1;
                    m_st = 0;
                end
            end
            default: ;
        endcase
        if (bus.cfg_ack && m_st == 2 && m_n < CL) begin
            chk("word", 32'(bus.cfg_data), exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
            m_n++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [23:0] d, input bit ok);
        bus.wr_en = 1'b1;
        bus.wr_addr = 8'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        if (ok && a < CL) bm[a] = d;
        chk("wr_reject", 32'(bus.reject), 32'(!ok));
    endtask

    task automatic commit(input bit fresh);
        bus.commit = 1'b1;
        if (fresh) begin
            exp_q.delete();
            for (int i = 0; i < CL; i++) exp_q.push_back(32'(bm[i]));
        end
        tick();
        bus.commit = 1'b0;
        if (fresh) begin
            chk("commit_req", 32'(bus.cfg_req), 1);
            chk("commit_busy", 32'(bus.busy), 1);
            chk("commit_err", 32'(bus.err), 0);
            chk("commit_code", 32'(bus.err_code), 0);
        end else begin
            chk("busy_commit_reject", 32'(bus.reject), 1);
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_in_budget", 32'(bus.busy), 0);
    endtask

    task automatic chk_ok_run(input string tag, input int d0);
        chk({tag, "_done"}, 32'(n_done - d0), 1);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_code"}, 32'(bus.err_code), 0);
        chk({tag, "_left"}, 32'(exp_q.size()), 0);
        chk({tag, "_words"}, 32'(m_n), CL);
    endtask

    initial begin
        int n, d0, r0, q0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 1'b0;
        bus.cfg_ack = 1'b0; bus.cfg_done = 1'b0;
        tick();
        chk("rst_req", 32'(bus.cfg_req), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_code", 32'(bus.err_code), 0);
        chk("rst_data", 32'(bus.cfg_data), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_reject", 32'(bus.reject), 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < CL; i++) wr(i, 24'(i + 'h100), 1'b1);

        // nominal download, ACK one cycle after request, ACK held 2 extra cycles
        xtra = 2; d0 = n_done; q0 = n_req;
        commit(1'b1);
        wait_idle(1000, n);
        chk("req_cycles", 32'(n_req - q0), 2);
        chk_ok_run("nominal", d0);

        // ACK never arrives
        ack_dly = 1 << 30; xtra = 0;
        commit(1'b1);
        wait_idle(5000, n);
        chk("ack_to_cycles", 32'(n), 4096);
        chk("ack_to_code", 32'(bus.err_code), 1);
        chk("ack_to_err", 32'(bus.err), 1);
        chk("ack_to_req", 32'(bus.cfg_req), 0);
        repeat (3) tick();
        chk("ack_to_err_held", 32'(bus.err), 1);
        chk("ack_to_code_held", 32'(bus.err_code), 1);

        // ACK lost after word 50, then a clean recommit
        ack_dly = 1; drop_at = 51;
        commit(1'b1);
        wait_idle(500, n);
        chk("ack_lost_code", 32'(bus.err_code), 2);
        chk("ack_lost_err", 32'(bus.err), 1);
        chk("ack_lost_words", 32'(m_n), 51);
        drop_at = -1; d0 = n_done;
        commit(1'b1);
        wait_idle(1000, n);
        chk_ok_run("recommit", d0);

        // done never arrives
        done_dly = 1 << 30;
        commit(1'b1);
        wait_idle(6000, n);
        chk("done_to_cycles", 32'(n), 2 + (CL - 1) + 4096);
        chk("done_to_code", 32'(bus.err_code), 3);
        chk("done_to_err", 32'(bus.err), 1);
        done_dly = 200;

        // dropped write, dropped commit, out-of-range write
        r0 = n_rej; d0 = n_done;
        commit(1'b1);
        wr(5, 24'hBAD, 1'b0);
        commit(1'b0);
        wait_idle(1000, n);
        chk_ok_run("busy_rejects", d0);
        wr(CL, 24'h5A5A5A, 1'b0);
        tick();
        chk("reject_pulses", 32'(n_rej - r0), 3);

        // reset mid-stream, then restart with a same-cycle write to word 0
        commit(1'b1);
        n = 0;
        while (m_n < 90 && n < 300) begin
            tick();
            n++;
        end
        chk("reached_word90", 32'(m_n >= 90), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.cfg_req), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_data", 32'(bus.cfg_data), 0);
        chk("mid_rst_err", 32'(bus.err), 0);
        chk("mid_rst_code", 32'(bus.err_code), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        d0 = n_done;
        chk("no_done_on_reset", 32'(n_done - d0), 0);
        bus.wr_en = 1'b1; bus.wr_addr = 8'd0; bus.wr_data = 24'hABCDEF;
        bm[0] = 24'hABCDEF;
        commit(1'b1);
        bus.wr_en = 1'b0;
        wait_idle(1000, n);
        chk_ok_run("restart", d0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
